// File: rtl/mult_rr_arbiter.sv
// Round-robin sharing of one sequential multiplier among N_REQ requesters; ack one cycle after m_finish, req held until ack.
// Define MULT_ARB_TIMEOUT_EN to abort a WAIT after TIMEOUT cycles (ack with result=0, overflow=1, timeout_err=1).
module mult_rr_arbiter #(
  parameter int N_REQ        = 4,
  parameter int WIDTH        = 16,
  parameter int START_CYCLES = 4,
  parameter int TIMEOUT      = 63
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] a_bus,
  input  logic [N_REQ*WIDTH-1:0] b_bus,
  output logic [N_REQ-1:0]       ack,
  output logic [WIDTH-1:0]       result,
  output logic                   overflow,
  output logic                   busy,
  output logic                   timeout_err,
  output logic [WIDTH-1:0]       m_a,
  output logic [WIDTH-1:0]       m_b,
  output logic                   m_start,
  input  logic [WIDTH-1:0]       m_result,
  input  logic                   m_overflow,
  input  logic                   m_finish
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  if (N_REQ < 2 || N_REQ > 8 || START_CYCLES < 1 || TIMEOUT < 1) begin : g_bad_cfg
    $error("mult_rr_arbiter: illegal parameter set");
  end

  logic [1:0]       r_state;
  logic [PW-1:0]    r_ptr;
  logic [PW-1:0]    r_grant;
  logic [CW-1:0]    r_cnt;
  logic [N_REQ-1:0] r_ack;
  logic [WIDTH-1:0] r_result;
  logic             r_ovf;
  logic [WIDTH-1:0] r_ma;
  logic [WIDTH-1:0] r_mb;
  logic             r_start;
  logic             w_found;
  logic [PW-1:0]    w_pick;
  int               w_idx;

  // Scan starts just after the last winner so it becomes lowest priority.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = (int'(r_ptr) + k) % N_REQ;
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx[PW-1:0];
      end
    end
  end

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_wcnt;
  logic          r_tmo;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_ptr    <= PW'(N_REQ - 1);
      r_grant  <= '0;
      r_cnt    <= '0;
      r_ack    <= '0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_ma     <= '0;
      r_mb     <= '0;
      r_start  <= 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
      r_wcnt   <= '0;
      r_tmo    <= 1'b0;
`endif
    end else begin
      r_ack <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant <= w_pick;
            r_ma    <= a_bus[w_pick*WIDTH +: WIDTH];
            r_mb    <= b_bus[w_pick*WIDTH +: WIDTH];
            r_start <= 1'b1;
            r_cnt   <= CW'(START_CYCLES - 1);
            r_state <= S_START;
          end
        end
        S_START: begin
          if (r_cnt == '0) begin
            r_start <= 1'b0;
            r_state <= S_WAIT;
`ifdef MULT_ARB_TIMEOUT_EN
            r_wcnt  <= '0;
`endif
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_WAIT: begin
          if (m_finish) begin
            r_result       <= m_result;
            r_ovf          <= m_overflow;
            r_ack[r_grant] <= 1'b1;
            r_ptr          <= r_grant;
            r_state        <= S_DONE;
          end
`ifdef MULT_ARB_TIMEOUT_EN
          else if (r_wcnt == TW'(TIMEOUT - 1)) begin
            r_result       <= '0;
            r_ovf          <= 1'b1;
            r_tmo          <= 1'b1;
            r_ack[r_grant] <= 1'b1;
            r_ptr          <= r_grant;
            r_state        <= S_DONE;
          end else begin
            r_wcnt <= r_wcnt + 1'b1;
          end
`endif
        end
        S_DONE: begin
          r_state <= S_IDLE;
`ifdef MULT_ARB_TIMEOUT_EN
          r_tmo   <= 1'b0;
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef MULT_ARB_TIMEOUT_EN
  assign timeout_err = r_tmo;
`else
  assign timeout_err = 1'b0;
`endif

  assign ack      = r_ack;
  assign result   = r_result;
  assign overflow = r_ovf;
  assign busy     = (r_state != S_IDLE);
  assign m_a      = r_ma;
  assign m_b      = r_mb;
  assign m_start  = r_start;

endmodule

// File: tb/tb_mult_rr_arbiter.sv
// Directed bench for mult_rr_arbiter with an adder stub standing in for the multiplier.
// Expected acks are queued when requests are raised and checked in order as acks appear.
module tb_mult_rr_arbiter;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int SC = 4;
  localparam int TO = 63;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] a_bus = '0;
  logic [N*W-1:0] b_bus = '0;
  logic [N-1:0]   ack;
  logic [W-1:0]   result;
  logic           overflow;
  logic           busy;
  logic           timeout_err;
  logic [W-1:0]   m_a;
  logic [W-1:0]   m_b;
  logic           m_start;
  logic [W-1:0]   m_result;
  logic           m_overflow;
  logic           m_finish;

  mult_rr_arbiter #(.N_REQ(N), .WIDTH(W), .START_CYCLES(SC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .a_bus(a_bus), .b_bus(b_bus),
    .ack(ack), .result(result), .overflow(overflow), .busy(busy),
    .timeout_err(timeout_err), .m_a(m_a), .m_b(m_b), .m_start(m_start),
    .m_result(m_result), .m_overflow(m_overflow), .m_finish(m_finish)
  );

  always #5 clk = ~clk;

  // Stub multiplier: sum of operands, finish 12 cycles after start falls.
  logic stub_en = 1'b1;
  logic armed   = 1'b0;
  int   sc_cnt  = 0;
  logic fin     = 1'b0;
  assign m_result   = m_a + m_b;
  assign m_overflow = m_a[15];
  assign m_finish   = fin;

  always @(posedge clk) begin
    if (rst) begin
      fin <= 1'b0; armed <= 1'b0; sc_cnt <= 0;
    end else if (m_start) begin
      fin <= 1'b0; armed <= 1'b1; sc_cnt <= 0;
    end else if (armed && stub_en) begin
      if (sc_cnt == 11) begin
        fin <= 1'b1; armed <= 1'b0;
      end else begin
        sc_cnt <= sc_cnt + 1;
      end
    end
  end

  typedef struct {
    int         id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic       ovf;
    logic       tmo;
  } exp_t;

  exp_t         q[$];
  int           vecs  = 0;
  int           errs  = 0;
  int           run   = 0;
  int           age   = 0;
  int           n_ack = 0;
  logic [N-1:0] hold  = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    exp_t e;
    @(negedge clk);
    if (age == 1) begin
      chk("busy_gap", 32'(busy), 0);
      chk("tmo_clear", 32'(timeout_err), 0);
      age = (req != 0) ? 2 : 0;
    end else if (age == 2) begin
      chk("busy_regrant", 32'(busy), 1);
      age = 0;
    end
    if (m_start) begin
      run++;
      if (q.size() != 0) begin
        chk("m_a", 32'(m_a), 32'(q[0].a));
        chk("m_b", 32'(m_b), 32'(q[0].b));
      end
    end else if (run != 0) begin
      chk("m_start_len", run, SC);
      run = 0;
    end
    if (ack != 0) begin
      n_ack++;
      age = 1;
      if (q.size() == 0) begin
        chk("unexpected_ack", 32'(ack), 0);
      end else begin
        e = q.pop_front();
        chk("ack_id", 32'(ack), 32'(1) << e.id);
        chk("result", 32'(result), 32'(e.res));
        chk("overflow", 32'(overflow), 32'(e.ovf));
        chk("timeout_err", 32'(timeout_err), 32'(e.tmo));
      end
      for (int i = 0; i < N; i++)
        if (ack[i] && !hold[i]) req[i] = 1'b0;
      if (q.size() == 0) begin
        req  = req & ~hold;
        hold = '0;
      end
    end
  endtask

  task automatic setop(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
    a_bus[id*W +: W] = a;
    b_bus[id*W +: W] = b;
  endtask

  task automatic push(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.id = id; e.a = a; e.b = b; e.res = a + b; e.ovf = a[15]; e.tmo = 1'b0;
    q.push_back(e);
  endtask

  task automatic wait_done(input int bound, output int n);
    n = 0;
    while (q.size() != 0 && n < bound) begin
      cyc();
      n++;
    end
    if (q.size() != 0) begin
      chk("ack_wait_expired", q.size(), 0);
      q.delete();
    end
    cyc();
    cyc();
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; hold = '0; q.delete(); run = 0; age = 0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ack"}, 32'(ack), 0);
    chk({tag, "_result"}, 32'(result), 0);
    chk({tag, "_overflow"}, 32'(overflow), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_tmo"}, 32'(timeout_err), 0);
    chk({tag, "_m_a"}, 32'(m_a), 0);
    chk({tag, "_m_b"}, 32'(m_b), 0);
    chk({tag, "_m_start"}, 32'(m_start), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int saved;

    // Power-on reset
    do_reset();
    chk_idle("por");

    // Single request; operand bus changes after grant must be ignored
    setop(0, 16'h0003, 16'h0005);
    req = 4'b0001;
    push(0, 16'h0003, 16'h0005);
    cyc();
    cyc();
    setop(0, 16'hffff, 16'hffff);
    wait_done(200, n);
    cyc();
    chk("result_hold", 32'(result), 32'h0008);
    chk("overflow_hold", 32'(overflow), 0);

    // All four simultaneously from a fresh pointer
    do_reset();
    for (int i = 0; i < N; i++) begin
      setop(i, W'(16'h0100 * (i + 1) + i), W'(16'h0011 * (i + 1)));
      push(i, W'(16'h0100 * (i + 1) + i), W'(16'h0011 * (i + 1)));
    end
    req = 4'b1111;
    wait_done(400, n);

    // Fairness between two continuously held requesters (pointer now 3)
    setop(0, 16'h0100, 16'h0001);
    setop(2, 16'h0200, 16'h0002);
    hold = 4'b0101;
    req  = 4'b0101;
    for (int k = 0; k < 2; k++) begin
      push(0, 16'h0100, 16'h0001);
      push(2, 16'h0200, 16'h0002);
    end
    wait_done(400, n);

    // Overflow passthrough
    setop(1, 16'h8001, 16'h0001);
    req = 4'b0010;
    push(1, 16'h8001, 16'h0001);
    wait_done(200, n);
    chk("ovf_result_hold", 32'(result), 32'h8002);

    // Reset while waiting on the multiplier: op dropped, no ack
    setop(0, 16'h0007, 16'h0009);
    req = 4'b0001;
    for (int k = 0; k < SC + 4; k++) cyc();
    chk("in_wait", 32'(busy & ~m_start), 1);
    saved = n_ack;
    rst = 1'b1; req = '0; run = 0; age = 0;
    cyc();
    chk_idle("midrst");
    rst = 1'b0;
    for (int k = 0; k < 20; k++) cyc();
    chk("no_ack_after_rst", n_ack, saved);
    setop(2, 16'h1000, 16'h0234);
    req = 4'b0100;
    push(2, 16'h1000, 16'h0234);
    wait_done(200, n);

    // Multiplier never finishes
    stub_en = 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
    begin
      exp_t e;
      setop(0, 16'h1234, 16'h0001);
      e.id = 0; e.a = 16'h1234; e.b = 16'h0001; e.res = '0; e.ovf = 1'b1; e.tmo = 1'b1;
      q.push_back(e);
      req = 4'b0001;
      wait_done(300, n);
      chk("timeout_latency", n, SC + TO + 1);
    end
`else
    setop(0, 16'h1234, 16'h0001);
    saved = n_ack;
    req = 4'b0001;
    for (int k = 0; k < 500; k++) cyc();
    chk("hang_no_ack", n_ack, saved);
    chk("hang_busy", 32'(busy), 1);
    chk("hang_tmo", 32'(timeout_err), 0);
`endif
    stub_en = 1'b1;
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/mult_rr_arbiter.md
Name: mult_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one sequential fixed-point multiplier among N_REQ requesters.
- Multiplier side: clk, rst, a, b, start, result, overflow_flag, finish.
- Per operation: latches the winner's operands, drives start for START_CYCLES cycles, waits for finish, registers result/overflow and pulses the winner's ack.
- Sits between the ODE solver update stages and the shared multiplier.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 16, operand/result width.
- START_CYCLES, 4, cycles m_start is held high per operation (≥1).
- TIMEOUT, 63, max WAIT cycles before abort (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-requester request, held until ack.
- a_bus  in  N_REQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH].
- b_bus  in  N_REQ*WIDTH  operand B, same packing.
- ack  out  N_REQ  one-cycle completion pulse, one-hot.
- result  out  WIDTH  product of last completed op, held until next completion.
- overflow  out  1  overflow flag of last completed op.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  abort indicator (optional feature; tied 0 otherwise).
- m_a  out  WIDTH  multiplier operand A, stable from START entry to DONE.
- m_b  out  WIDTH  multiplier operand B.
- m_start  out  1  multiplier start.
- m_result  in  WIDTH  multiplier result.
- m_overflow  in  1  multiplier overflow_flag.
- m_finish  in  1  multiplier finish.

Behaviour:
- Clock is clk; reset is rst, synchronous, active-high.
- Reset (also mid-operation): state=IDLE; ack, result, overflow, busy, timeout_err, m_a, m_b, m_start all 0. Priority pointer=N_REQ-1, so req[0] has top priority first. An in-flight op is dropped with no ack.
- FSM states: IDLE, START, WAIT, DONE.
- IDLE:
  - If any req bit is high, pick the first set bit scanning from pointer+1 upward with wrap.
  - Latch grant id and its a/b into m_a/m_b; go to START.
  - If req==0, stay in IDLE.
- START: m_start=1 for exactly START_CYCLES cycles (down-counter), then go to WAIT with m_start=0. m_finish is ignored in START.
- WAIT:
  - m_start=0.
  - On the edge where m_finish==1: register result<=m_result, overflow<=m_overflow, ack[grant]<=1, pointer<=grant; go to DONE.
- DONE: ack high for this single cycle; next edge goes to IDLE, ack returns to 0.
- Latency: req sampled in IDLE at edge k → m_start high cycles k+1..k+START_CYCLES. Ack is high the cycle after m_finish is sampled. Minimum req-to-next-grant gap is 1 IDLE cycle.
- Requester rule: drop req on the edge where ack is sampled high. A req still high in IDLE counts as a new request; it gets lowest priority because the pointer equals its index.
- Operand changes on a/b_bus after grant have no effect.
- Simultaneous requests: exactly one grant per operation; no requester waits more than N_REQ-1 operations.
- Single active requester: it is re-granted back-to-back.
- busy = (state != IDLE).

Optional Feature:
- Macro: MULT_ARB_TIMEOUT_EN.
- With macro:
  - WAIT counter counts cycles. If it reaches TIMEOUT without m_finish, go to DONE with ack[grant]=1, result=0, overflow=1, timeout_err=1 for that cycle; pointer still advances.
  - timeout_err clears in IDLE.
- Without macro: no counter; WAIT waits indefinitely; timeout_err constant 0.

Test Plan:
Bench uses a stub multiplier: result=A+B, overflow=A[15], finish rises 12 cycles after m_start falls, clears on m_start.
- Reset then single request: req=4'b0001, a=16'h0003, b=16'h0005 → m_start high exactly 4 cycles, m_a/m_b=0003/0005, ack=4'b0001 one cycle with result=16'h0008, overflow=0.
- All four request simultaneously with distinct operands → grants in order 0,1,2,3; each ack carries the matching sum; busy low exactly one cycle between ops.
- Fairness: req[0] and req[2] held continuously → grants alternate 0,2,0,2; req[1]=req[3]=0 never acked.
- Overflow passthrough: a=16'h8001, b=16'h0001 → result=16'h8002, overflow=1.
- rst asserted during WAIT → next cycle: all outputs 0, state IDLE, no ack. Following req=4'b0100 is granted normally.
- With MULT_ARB_TIMEOUT_EN, stub never raises finish → ack after START_CYCLES+63 WAIT cycles with result=0, overflow=1, timeout_err=1. Without the macro, no ack after 500 cycles.
